em4100_decoder: RTL and testbench

//  Receive-side partner of the EM4100 transmitter: recovers the Manchester-coded 64-bit EM4100 frame

---
 rtl/em4100_pkg.sv | 36 +++
 rtl/em4100_bit_recovery.sv | 116 +++++++++++
 rtl/em4100_decoder.sv | 95 +++++++++
 tb/tb_em4100_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/em4100_pkg.sv
// Shared EM4100 definitions: frame geometry, bit positions and the
// bit-recovery state encoding used by both the transmitter and the decoder.
package em4100_pkg;

   localparam int EM4100_FRAME_BITS  = 64;
   localparam int EM4100_HEADER_BITS = 9;
   localparam int EM4100_DATA_BITS   = 40;
   localparam int EM4100_ROWS        = 10;
   localparam int EM4100_COLS        = 4;
   localparam int EM4100_ROW_BITS    = 5;   // 4 data bits + even parity
   localparam int EM4100_ROW_BASE    = EM4100_HEADER_BITS;
   localparam int EM4100_COL_BASE    = EM4100_ROW_BASE + EM4100_ROWS * EM4100_ROW_BITS;
   localparam int EM4100_STOP_IDX    = EM4100_FRAME_BITS - 1;

   // Bit-recovery FSM states; MID and BOUNDARY both count as locked.
   typedef enum logic [1:0] {
      HUNT     = 2'd0,
      MID      = 2'd1,
      BOUNDARY = 2'd2
   } rec_state_t;

   // Classification of the interval between two line edges.
   typedef enum logic [1:0] {
      IV_GLITCH  = 2'd0,
      IV_SHORT   = 2'd1,
      IV_LONG    = 2'd2,
      IV_TIMEOUT = 2'd3
   } interval_t;

   // Frame position (index 0 = oldest bit) of column c of data row r;
   // c = 4 addresses the row parity bit.
   function automatic int row_bit_idx(input int r, input int c);
      return EM4100_ROW_BASE + r * EM4100_ROW_BITS + c;
   endfunction

endpackage

// File: rtl/em4100_bit_recovery.sv
// Manchester bit recovery: synchronises the line, measures the time between
// edges and tracks cell phase so that a bit is emitted on every mid-cell edge.
// Handshake: rx_bit is meaningful only in the cycle bit_strobe is high; there
// is no back-pressure, the consumer must take every strobed bit.
module em4100_bit_recovery
   import em4100_pkg::*;
#(
   parameter int HALF_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic       rx_bit,
   output logic       bit_strobe,
   output logic       locked,
   output rec_state_t state
);

   localparam int TW = $clog2(3 * HALF_BIT + 1);
   localparam logic [TW-1:0] T_SAT   = TW'(3 * HALF_BIT);
   localparam logic [TW-1:0] T_SHORT = TW'(HALF_BIT / 2);
   localparam logic [TW-1:0] T_LONG  = TW'((3 * HALF_BIT) / 2);
   localparam logic [TW-1:0] T_TMO   = TW'((5 * HALF_BIT) / 2);

   logic          sync1, sync2, line_q;
   logic          edge_det;
   logic [TW-1:0] timer;
   interval_t     iv;
   rec_state_t    state_n;

   // Two-flop synchroniser followed by a one-flop history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         line_q <= 1'b0;
      end else begin
         sync1  <= din;
         sync2  <= sync1;
         line_q <= sync2;
      end
   end

   assign edge_det = sync2 ^ line_q;
   // New level after the edge is the edge direction: 1 = rising = bit 1.
   assign rx_bit   = sync2;

   // Cycles since the last edge, saturating well past the timeout threshold.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (edge_det) begin
         timer <= '0;
      end else if (timer != T_SAT) begin
         timer <= timer + 1'b1;
      end
   end

   // Bucket the elapsed time into glitch / short / long / timeout.
   always_comb begin
      iv = IV_TIMEOUT;
      if (timer < T_SHORT) begin
         iv = IV_GLITCH;
      end else if (timer < T_LONG) begin
         iv = IV_SHORT;
      end else if (timer < T_TMO) begin
         iv = IV_LONG;
      end
   end

   // Recovery state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_n;
      end
   end

   // Edge-driven phase tracking; a quiet line in a locked state drops to HUNT.
   always_comb begin
      state_n    = state;
      bit_strobe = 1'b0;
      if (edge_det) begin
         case (state)
            HUNT: begin
               if (iv == IV_LONG) begin
                  state_n    = MID;
                  bit_strobe = 1'b1;
               end
            end
            MID: begin
               case (iv)
                  IV_SHORT: state_n = BOUNDARY;
                  IV_LONG:  bit_strobe = 1'b1;
                  default:  state_n = HUNT;
               endcase
            end
            BOUNDARY: begin
               if (iv == IV_SHORT) begin
                  state_n    = MID;
                  bit_strobe = 1'b1;
               end else begin
                  state_n = HUNT;
               end
            end
            default: state_n = HUNT;
         endcase
      end else if (timer >= T_TMO && state != HUNT) begin
         state_n = HUNT;
      end
   end

   assign locked = (state == MID) || (state == BOUNDARY);

endmodule

// File: rtl/em4100_decoder.sv
// EM4100 receiver top: collects recovered bits in a 64-bit window, checks
// header, stop bit and all row/column parities after every new bit, and
// publishes the 40-bit payload with a one-cycle data_valid strobe.
module em4100_decoder
   import em4100_pkg::*;
#(
   parameter int HALF_BIT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        din,
   output logic [EM4100_DATA_BITS-1:0] data_out,
   output logic                        data_valid,
   output logic                        parity_err,
   output logic                        locked
);

   logic                         rx_bit;
   logic                         bit_strobe;
   rec_state_t                   rec_state;
   logic [EM4100_FRAME_BITS-1:0] sr;
   logic                         chk_pend;
   logic [EM4100_DATA_BITS-1:0]  payload;
   logic [EM4100_ROWS-1:0]       row_par;
   logic [EM4100_COLS-1:0]       col_par;
   logic                         framed;
   logic                         par_ok;

   em4100_bit_recovery #(
      .HALF_BIT (HALF_BIT)
   ) u_rec (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .rx_bit     (rx_bit),
      .bit_strobe (bit_strobe),
      .locked     (locked),
      .state      (rec_state)
   );

   // Payload extraction and per-row even parity (1 = row parity broken).
   for (genvar r = 0; r < EM4100_ROWS; r++) begin : g_row
      assign payload[r*EM4100_COLS +: EM4100_COLS] = sr[row_bit_idx(r, 0) +: EM4100_COLS];
      assign row_par[r] = ^sr[row_bit_idx(r, 0) +: EM4100_ROW_BITS];
   end

   // Per-column even parity across the ten rows plus the column parity bit.
   for (genvar c = 0; c < EM4100_COLS; c++) begin : g_col
      logic [EM4100_ROWS-1:0] col_bits;
      for (genvar r = 0; r < EM4100_ROWS; r++) begin : g_bit
         assign col_bits[r] = sr[row_bit_idx(r, c)];
      end
      assign col_par[c] = (^col_bits) ^ sr[EM4100_COL_BASE + c];
   end

   assign framed = (&sr[EM4100_HEADER_BITS-1:0]) & ~sr[EM4100_STOP_IDX];
   assign par_ok = ~(|row_par) & ~(|col_par);

   // Shift window: newest bit enters at the MSB; a framed check clears it so
   // the same bits can never match twice. HUNT deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr       <= '0;
         chk_pend <= 1'b0;
      end else begin
         chk_pend <= bit_strobe;
         if (chk_pend && framed) begin
            sr <= '0;
         end else if (bit_strobe) begin
            sr <= {rx_bit, sr[EM4100_FRAME_BITS-1:1]};
         end
      end
   end

   // Registered verdict one cycle after each new bit; strobes are exclusive.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         if (chk_pend && framed) begin
            if (par_ok) begin
               data_valid <= 1'b1;
               data_out   <= payload;
            end else begin
               parity_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_em4100_decoder.sv
// Bench for em4100_decoder: a Manchester line driver built from an
// independent EM4100 frame encoder, a scoreboard of expected payloads and
// one task per scenario.
module tb_em4100_decoder;

   localparam int HB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic [39:0] data_out;
   logic        data_valid;
   logic        parity_err;
   logic        locked;

   int total    = 0;
   int bad      = 0;
   int cyc      = 0;
   int stop_cyc = 0;
   int pe_count = 0;
   int dv_count = 0;

   logic [39:0] exp_q[$];

   bit jitter_mode = 1'b0;
   bit jit_toggle  = 1'b0;
   bit glitch_seen = 1'b0;

   em4100_decoder #(
      .HALF_BIT (HB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .locked     (locked)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // scoreboard: pop expected payload on every data_valid, check latency
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid || parity_err) begin
            total++;
            if (data_valid && parity_err) begin
               bad++;
               $display("FAIL exclusive: data_valid=1 parity_err=1, required at most one");
            end
         end
         if (parity_err) pe_count++;
         if (data_valid) begin
            dv_count++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid: data_out=%h, required no output", data_out);
            end else begin
               logic [39:0] e;
               e = exp_q.pop_front();
               if (data_out !== e) begin
                  bad++;
                  $display("FAIL payload: data_out=%h required=%h", data_out, e);
               end
            end
            total++;
            if (cyc - stop_cyc !== 4) begin
               bad++;
               $display("FAIL latency: %0d cycles after stop edge, required 4", cyc - stop_cyc);
            end
         end
      end
   end

   // independent EM4100 encoder: index 0 = first bit on the line
   function automatic logic [63:0] build_frame(input logic [39:0] d);
      logic [63:0] f;
      logic        cp;
      f = '0;
      for (int i = 0; i < 9; i++) f[i] = 1'b1;
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 4; c++) f[9 + 5*r + c] = d[4*r + c];
         f[9 + 5*r + 4] = ^d[4*r +: 4];
      end
      for (int c = 0; c < 4; c++) begin
         cp = 1'b0;
         for (int r = 0; r < 10; r++) cp = cp ^ d[4*r + c];
         f[59 + c] = cp;
      end
      f[63] = 1'b0;
      return f;
   endfunction

   function automatic logic [39:0] rand_data();
      return {8'($urandom_range(0, 255)), 32'($urandom)};
   endfunction

   // driver: one half-cell at the current level, optional 3-cycle glitch
   task automatic drive_half(input logic lvl, input bit is_stop_mid, input bit glitch);
      int n;
      if (jitter_mode) begin
         jit_toggle = ~jit_toggle;
         n = jit_toggle ? 12 : 20;
      end else begin
         n = HB;
      end
      din = lvl;
      if (is_stop_mid) stop_cyc = cyc;
      if (glitch) begin
         repeat (6) @(negedge clk);
         din = ~lvl;
         glitch_seen = 1'b1;
         repeat (3) @(negedge clk);
         din = lvl;
         repeat (n - 9) @(negedge clk);
      end else begin
         repeat (n) @(negedge clk);
      end
   endtask

   // driver: optional lead-in 0 bit, then the 64-bit frame
   task automatic send_frame(input logic [63:0] f, input bit lead_in, input int gbit);
      @(negedge clk);
      if (lead_in) begin
         drive_half(1'b1, 1'b0, 1'b0);
         drive_half(1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 64; i++) begin
         drive_half(~f[i], 1'b0, 1'b0);
         drive_half(f[i], i == 63, i == gbit);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (data_out !== 40'h0) begin bad++; $display("FAIL reset_data_out: got=%h required=0", data_out); end
      total++;
      if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got=%b required=0", data_valid); end
      total++;
      if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got=%b required=0", parity_err); end
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got=%b required=0", locked); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_loopback();
      int dv0;
      dv0 = dv_count;
      exp_q.push_back(40'hA5_1234_5678);
      send_frame(build_frame(40'hA5_1234_5678), 1'b1, -1);
      exp_q.push_back(40'hA5_1234_5678);
      send_frame(build_frame(40'hA5_1234_5678), 1'b0, -1);
      total++;
      if (dv_count - dv0 !== 2) begin bad++; $display("FAIL loop_count: valids=%0d required=2", dv_count - dv0); end
      total++;
      if (pe_count !== 0) begin bad++; $display("FAIL loop_parity: parity_err=%0d required=0", pe_count); end
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL loop_pending: left=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_parity_flip();
      logic [63:0] f;
      int          dv0, pe0;
      dv0 = dv_count;
      pe0 = pe_count;
      f = build_frame(40'hA5_1234_5678);
      f[25] = ~f[25];
      send_frame(f, 1'b1, -1);
      total++;
      if (pe_count - pe0 !== 1) begin bad++; $display("FAIL flip_parity_err: pulses=%0d required=1", pe_count - pe0); end
      total++;
      if (dv_count !== dv0) begin bad++; $display("FAIL flip_valid: valids=%0d required=0", dv_count - dv0); end
      total++;
      if (data_out !== 40'hA5_1234_5678) begin bad++; $display("FAIL flip_held: data_out=%h required=a512345678", data_out); end
   endtask

   task automatic test_jitter();
      jitter_mode = 1'b1;
      exp_q.push_back(40'h3C_9E01_B7D2);
      send_frame(build_frame(40'h3C_9E01_B7D2), 1'b1, -1);
      jitter_mode = 1'b0;
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL jitter_pending: left=%0d required=0", exp_q.size()); end
      total++;
      if (data_out !== 40'h3C_9E01_B7D2) begin bad++; $display("FAIL jitter_data: data_out=%h required=3c9e01b7d2", data_out); end
   endtask

   task automatic test_glitch();
      int dv0, pe0;
      dv0 = dv_count;
      pe0 = pe_count;
      glitch_seen = 1'b0;
      fork
         send_frame(build_frame(40'hA5_1234_5678), 1'b1, 4);
         begin : watch
            int k;
            k = 0;
            while (!glitch_seen && k < 5000) begin
               @(negedge clk);
               k++;
            end
            total++;
            if (!glitch_seen) begin bad++; $display("FAIL glitch_wait: glitch not reached within 5000 cycles"); end
            total++;
            if (locked !== 1'b1) begin bad++; $display("FAIL glitch_pre_lock: locked=%b required=1", locked); end
            repeat (5) @(negedge clk);
            total++;
            if (locked !== 1'b0) begin bad++; $display("FAIL glitch_lock_drop: locked=%b required=0", locked); end
         end
      join
      total++;
      if (dv_count !== dv0 || pe_count !== pe0) begin
         bad++;
         $display("FAIL glitch_lost: valids=%0d parity_errs=%0d required 0 and 0", dv_count - dv0, pe_count - pe0);
      end
      exp_q.push_back(40'h01_2345_6789);
      send_frame(build_frame(40'h01_2345_6789), 1'b1, -1);
      total++;
      if (data_out !== 40'h01_2345_6789) begin bad++; $display("FAIL glitch_recover: data_out=%h required=0123456789", data_out); end
   endtask

   task automatic test_timeout();
      logic [39:0] d;
      d = rand_data();
      exp_q.push_back(d);
      send_frame(build_frame(d), 1'b1, -1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL tmo_locked: locked=%b required=1", locked); end
      repeat (60) @(negedge clk);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL tmo_unlock: locked=%b required=0", locked); end
      total++;
      if (data_out !== d) begin bad++; $display("FAIL tmo_held: data_out=%h required=%h", data_out, d); end
      d = rand_data();
      exp_q.push_back(d);
      send_frame(build_frame(d), 1'b1, -1);
      total++;
      if (data_out !== d) begin bad++; $display("FAIL tmo_relock: data_out=%h required=%h", data_out, d); end
   endtask

   task automatic test_back_to_back();
      logic [39:0] d;
      int          dv0;
      dv0 = dv_count;
      for (int i = 0; i < 3; i++) begin
         d = rand_data();
         exp_q.push_back(d);
         send_frame(build_frame(d), i == 0, -1);
      end
      total++;
      if (dv_count - dv0 !== 3) begin bad++; $display("FAIL b2b_count: valids=%0d required=3", dv_count - dv0); end
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_pending: left=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_rst_mid_frame();
      int dv0, pe0;
      dv0 = dv_count;
      pe0 = pe_count;
      fork
         send_frame(build_frame(40'h5A_A5C3_3C0F), 1'b1, -1);
         begin
            repeat (700) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            total++;
            if (data_out !== 40'h0) begin bad++; $display("FAIL rst_data_out: got=%h required=0", data_out); end
            total++;
            if (data_valid !== 1'b0 || parity_err !== 1'b0) begin
               bad++;
               $display("FAIL rst_strobes: data_valid=%b parity_err=%b required 0 0", data_valid, parity_err);
            end
            total++;
            if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got=%b required=0", locked); end
            rst = 1'b0;
         end
      join
      total++;
      if (dv_count !== dv0 || pe_count !== pe0) begin
         bad++;
         $display("FAIL rst_partial: valids=%0d parity_errs=%0d required 0 and 0", dv_count - dv0, pe_count - pe0);
      end
      exp_q.push_back(40'hC7_0F1E_2D3B);
      send_frame(build_frame(40'hC7_0F1E_2D3B), 1'b1, -1);
      total++;
      if (data_out !== 40'hC7_0F1E_2D3B) begin bad++; $display("FAIL rst_next: data_out=%h required=c70f1e2d3b", data_out); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_parity_flip();
      test_jitter();
      test_glitch();
      test_timeout();
      test_back_to_back();
      test_rst_mid_frame();
      repeat (10) @(negedge clk);
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL final_pending: left=%0d required=0", exp_q.size()); end
      total++;
      if (pe_count !== 1) begin bad++; $display("FAIL final_parity_total: parity_err=%0d required=1", pe_count); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
